barrel_rotate_decoder: RTL and testbench

Sequential inverse of the 8-bit rotator. Given an original word and a rotated word, the block recovers the rotation that maps one to the other, as a direction and amount in the rotator's own encoding, or reports that no rotation matches. It tries one candidate amount per clock using a 1-bit rotate register. Producer and consumer connect through a valid/ready handshake, and the block sits on the check path beside the rotator.

---
 rtl/barrel_rotate_decoder_pkg.sv | 37 +++
 rtl/barrel_rotate_decoder_if.sv | 25 ++
 rtl/barrel_rotate_decoder.sv | 77 +++++++
 tb/tb_barrel_rotate_decoder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/barrel_rotate_decoder_pkg.sv
// Shared types, constants and helpers for the rotation decoder: the 1-bit
// rotate step and the mapping from a left-rotate count to the rotator's encoding.
package barrel_pkg;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_e;

  typedef struct packed {
    logic           dir;
    logic [SHW-1:0] shift;
  } rot_enc_t;

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] word);
    return {word[WIDTH-2:0], word[WIDTH-1]};
  endfunction

  // Counts up to half the width stay left; larger ones are the shorter right
  // rotation, so the half-width tie resolves to left.
  function automatic rot_enc_t enc_rot(input logic [SHW-1:0] k);
    rot_enc_t r;
    if (k <= SHW'(WIDTH / 2)) begin
      r.dir   = 1'b0;
      r.shift = k;
    end else begin
      r.dir   = 1'b1;
      r.shift = SHW'(WIDTH - int'(k));
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_rotate_decoder_if.sv
// Request/response handshake bundle between a producer/consumer (master)
// and the rotation decoder (slave).
interface barrel_rotate_decoder_if;

  logic                        in_valid;
  logic                        in_ready;
  logic [barrel_pkg::WIDTH-1:0] ref_word;
  logic [barrel_pkg::WIDTH-1:0] rot_word;
  logic                        out_valid;
  logic                        out_ready;
  logic                        found;
  logic                        dir;
  logic [barrel_pkg::SHW-1:0]   shift;

  modport master (
    output in_valid, ref_word, rot_word, out_ready,
    input  in_ready, out_valid, found, dir, shift
  );

  modport slave (
    input  in_valid, ref_word, rot_word, out_ready,
    output in_ready, out_valid, found, dir, shift
  );

endinterface

// File: rtl/barrel_rotate_decoder.sv
// Sequential inverse of the 8-bit rotator: steps the reference word left one
// bit per cycle until it equals the target or all rotations are exhausted.
module barrel_rotate_decoder
  import barrel_pkg::*;
#(
  parameter int WIDTH = barrel_pkg::WIDTH,
  parameter int SHW   = barrel_pkg::SHW
) (
  input  logic                     clk,
  input  logic                     rst,
  barrel_rotate_decoder_if.slave   bus
);

  state_e           state_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] target_q;
  logic [SHW-1:0]   k_q;
  logic             out_valid_q;
  logic             found_q;
  rot_enc_t         res_q;

  // NOTE: every register here is state, so all updates use non-blocking
  // assignments; blocking ones would let later statements see same-cycle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      target_q    <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      found_q     <= 1'b0;
      res_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_q   <= bus.ref_word;
            target_q <= bus.rot_word;
            k_q      <= '0;
            state_q  <= SEARCH;
          end
        end
        SEARCH: begin
          if (work_q == target_q) begin
            found_q     <= 1'b1;
            res_q       <= enc_rot(k_q);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else if (k_q == SHW'(WIDTH - 1)) begin
            found_q     <= 1'b0;
            res_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            work_q <= rotl1(work_q);
            k_q    <= k_q + SHW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        // NOTE: the unused state encoding recovers to IDLE instead of hanging.
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.found     = found_q;
  assign bus.dir       = res_q.dir;
  assign bus.shift     = res_q.shift;

endmodule

// File: tb/tb_barrel_rotate_decoder.sv
// Self-checking bench for barrel_rotate_decoder: directed cases plus random
// requests compared against an arithmetic rotation model.
module tb_barrel_rotate_decoder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  barrel_rotate_decoder_if bus ();

  barrel_rotate_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Smallest left-rotate count k with rotl(r,k)==t, then mapped to the
  // rotator's direction/amount encoding; latency is k+1, or 8 for a miss.
  function automatic void model(input int r, input int t, output logic f,
                                output logic d, output logic [2:0] s, output int lat);
    int rotated;
    f = 1'b0; d = 1'b0; s = 3'd0; lat = 8;
    for (int k = 7; k >= 0; k--) begin
      rotated = ((r << k) | (r >> (8 - k))) & 255;
      if (rotated == t) begin
        f   = 1'b1;
        d   = (k > 4);
        s   = (k > 4) ? 3'(8 - k) : 3'(k);
        lat = k + 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_req(input string tag, input logic [7:0] r, input logic [7:0] t);
    logic       m_found, m_dir;
    logic [2:0] m_shift;
    int         m_lat;
    int         lat;
    model(int'(r), int'(t), m_found, m_dir, m_shift, m_lat);
    check({tag, ".ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.ref_word = r;
    bus.rot_word = t;
    tick();
    bus.in_valid = 1'b0;
    bus.ref_word = 8'($urandom);
    bus.rot_word = 8'($urandom);
    check({tag, ".ready_busy"}, 32'(bus.in_ready), 32'd0);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(m_lat));
    check({tag, ".found"}, 32'(bus.found), 32'(m_found));
    check({tag, ".dir"}, 32'(bus.dir), 32'(m_dir));
    check({tag, ".shift"}, 32'(bus.shift), 32'(m_shift));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, ".valid_clr"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] r, t;
    int         amt;
    logic       h_found, h_dir;
    logic [2:0] h_shift;
    int         lat;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.ref_word  = 8'h00;
    bus.rot_word  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check("reset.in_ready", 32'(bus.in_ready), 32'd1);
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.found", 32'(bus.found), 32'd0);
    check("reset.dir", 32'(bus.dir), 32'd0);
    check("reset.shift", 32'(bus.shift), 32'd0);

    run_req("left1", 8'h81, 8'h03);
    run_req("right1", 8'h01, 8'h80);
    run_req("tie4", 8'h0F, 8'hF0);
    run_req("miss", 8'h12, 8'h34);
    run_req("per0", 8'h55, 8'h55);
    run_req("per1", 8'h55, 8'hAA);
    run_req("zero", 8'h00, 8'h00);
    run_req("ones", 8'hFF, 8'hFF);
    run_req("right3", 8'h01, 8'h20);

    // Backpressure with ignored requests while the result is held.
    bus.in_valid = 1'b1;
    bus.ref_word = 8'h81;
    bus.rot_word = 8'h03;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 16) begin
      tick();
      lat++;
    end
    check("bp.latency", 32'(lat), 32'd2);
    h_found = bus.found;
    h_dir   = bus.dir;
    h_shift = bus.shift;
    check("bp.found", 32'(h_found), 32'd1);
    check("bp.dir", 32'(h_dir), 32'd0);
    check("bp.shift", 32'(h_shift), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.ref_word = 8'($urandom);
      bus.rot_word = bus.ref_word;
      tick();
      check("bp.valid_hold", 32'(bus.out_valid), 32'd1);
      check("bp.found_hold", 32'(bus.found), 32'(h_found));
      check("bp.dir_hold", 32'(bus.dir), 32'(h_dir));
      check("bp.shift_hold", 32'(bus.shift), 32'(h_shift));
      check("bp.ready_low", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp.idle_ready", 32'(bus.in_ready), 32'd1);
    check("bp.idle_valid", 32'(bus.out_valid), 32'd0);
    tick();
    tick();
    check("bp.no_accept_ready", 32'(bus.in_ready), 32'd1);
    check("bp.no_accept_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the third search cycle of a k=7 request.
    bus.in_valid = 1'b1;
    bus.ref_word = 8'h01;
    bus.rot_word = 8'h80;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.found", 32'(bus.found), 32'd0);
    check("rst.shift", 32'(bus.shift), 32'd0);
    tick();
    tick();
    check("rst.stays_idle", 32'(bus.out_valid), 32'd0);
    run_req("after_rst", 8'h81, 8'h03);

    for (int n = 0; n < 40; n++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        amt = int'($urandom_range(0, 7));
        t   = 8'(((int'(r) << amt) | (int'(r) >> (8 - amt))) & 255);
      end else begin
        t = 8'($urandom);
      end
      run_req("rand", r, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
